// File: rtl/alu_muldiv_unit.sv
// Iterative RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// One shift-add or restoring-divide step per clock behind a START/READY/VALID handshake.
module alu_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic            FLUSH,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   input  logic [2:0]      SELECT,
   output logic            READY,
   output logic            VALID,
   output logic [XLEN-1:0] RESULT,
   output logic            zero_signal
);
   localparam int CNTW = $clog2(XLEN) + 1;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;

   logic              sign1_in, sign2_in;
   logic [XLEN-1:0]   mag1_in, mag2_in;
   logic              div_zero_in, overflow_in, special_in;
   logic [XLEN-1:0]   special_result_in;

   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [XLEN-1:0]   step_hi, step_lo;
   logic [2*XLEN-1:0] prod_mag, prod_signed;
   logic [XLEN-1:0]   quo_signed, rem_signed, final_result;

   // Operand decode at the accept edge: which operands are signed, their
   // magnitudes, and whether the operation resolves without iterating.
   always_comb begin
      sign1_in          = 1'b0;
      sign2_in          = 1'b0;
      special_result_in = '0;
      unique case (SELECT)
         OP_MUL, OP_MULHSU: sign1_in = DATA1[XLEN-1];
         OP_MULH, OP_DIV, OP_REM: begin
            sign1_in = DATA1[XLEN-1];
            sign2_in = DATA2[XLEN-1];
         end
         default: ;
      endcase

      mag1_in     = sign1_in ? (-DATA1) : DATA1;
      mag2_in     = sign2_in ? (-DATA2) : DATA2;
      div_zero_in = (DATA2 == '0);
      overflow_in = ((SELECT == OP_DIV) || (SELECT == OP_REM)) &&
                    (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
      special_in  = SELECT[2] && (div_zero_in || overflow_in);

      if (SELECT == OP_DIV || SELECT == OP_DIVU)
         special_result_in = div_zero_in ? '1 : DATA1;
      else
         special_result_in = div_zero_in ? DATA1 : '0;
   end

   // One iteration: shift-add for multiply, restoring trial-subtract for divide.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      if (op_q[2]) begin
         if (!div_diff[XLEN]) begin
            step_hi = div_diff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            step_hi = div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   // Sign correction on the final step's output, then pick the requested half.
   always_comb begin
      prod_mag    = {step_hi, step_lo};
      prod_signed = neg_q ? (-prod_mag) : prod_mag;
      quo_signed  = neg_q ? (-step_lo) : step_lo;
      rem_signed  = neg_q ? (-step_hi) : step_hi;
      unique case (op_q)
         OP_MUL:                       final_result = prod_signed[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_signed[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              final_result = quo_signed;
         default:                      final_result = rem_signed;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      neg_d    = neg_q;
      result_d = result_q;

      unique case (state_q)
         IDLE: begin
            if (START && !FLUSH) begin
               op_d  = SELECT;
               neg_d = (SELECT == OP_REM || SELECT == OP_REMU) ? sign1_in
                                                               : (sign1_in ^ sign2_in);
               if (special_in) begin
                  result_d = special_result_in;
                  cnt_d    = '0;
                  hi_d     = '0;
                  lo_d     = '0;
                  opb_d    = '0;
                  state_d  = DONE;
               end else begin
                  cnt_d   = CNTW'(XLEN);
                  hi_d    = '0;
                  lo_d    = SELECT[2] ? mag1_in : mag2_in;
                  opb_d   = SELECT[2] ? mag2_in : mag1_in;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (FLUSH) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               hi_d  = step_hi;
               lo_d  = step_lo;
               cnt_d = cnt_q - CNTW'(1);
               if (cnt_q == CNTW'(1)) begin
                  result_d = final_result;
                  state_d  = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         op_q     <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
      end
   end

   assign READY       = ready_q;
   assign VALID       = valid_q;
   assign RESULT      = result_q;
   assign zero_signal = ~|result_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit at XLEN=32 and XLEN=8, using directed
// cases plus randomized operations compared against an arithmetic reference model.
module tb_alu_muldiv_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start32, flush32;
   logic [31:0] data1_32, data2_32;
   logic [2:0]  select32;
   logic        ready32, valid32, zero32;
   logic [31:0] result32;

   logic        start8, flush8;
   logic [7:0]  data1_8, data2_8;
   logic [2:0]  select8;
   logic        ready8, valid8, zero8;
   logic [7:0]  result8;

   int checks = 0;
   int failures = 0;
   int overlapErrors = 0;
   logic [31:0] lastResult32;

   alu_muldiv_unit #(.XLEN(32)) dut32 (
      .CLK(clk), .RESET(reset), .START(start32), .FLUSH(flush32),
      .DATA1(data1_32), .DATA2(data2_32), .SELECT(select32),
      .READY(ready32), .VALID(valid32), .RESULT(result32), .zero_signal(zero32)
   );

   alu_muldiv_unit #(.XLEN(8)) dut8 (
      .CLK(clk), .RESET(reset), .START(start8), .FLUSH(flush8),
      .DATA1(data1_8), .DATA2(data2_8), .SELECT(select8),
      .READY(ready8), .VALID(valid8), .RESULT(result8), .zero_signal(zero8)
   );

   // READY and VALID must never be seen high together on either unit.
   always @(negedge clk) begin
      if (!reset && ((ready32 && valid32) || (ready8 && valid8)))
         overlapErrors++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] maskOf(input int xlen);
      return (xlen == 32) ? 32'hFFFF_FFFF : ((32'd1 << xlen) - 32'd1);
   endfunction

   // Arithmetic reference: widen to 64/128 bits, multiply or divide directly.
   function automatic logic [31:0] refModel(input int xlen, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
      logic [31:0]  mask, am, bm;
      longint       ua, ub, sa, sb, r, one, minNeg;
      logic [127:0] pa, pb, prod;
      mask   = maskOf(xlen);
      am     = a & mask;
      bm     = b & mask;
      ua     = {32'd0, am};
      ub     = {32'd0, bm};
      one    = 1;
      sa     = am[xlen-1] ? (ua - (one << xlen)) : ua;
      sb     = bm[xlen-1] ? (ub - (one << xlen)) : ub;
      minNeg = -(one << (xlen - 1));
      r      = 0;
      case (op)
         3'd0, 3'd1, 3'd2, 3'd3: begin
            pa   = (op == 3'd3) ? {96'd0, am} : {{64{sa[63]}}, sa};
            pb   = (op == 3'd1) ? {{64{sb[63]}}, sb} : {96'd0, bm};
            prod = pa * pb;
            if (op == 3'd0) return prod[31:0] & mask;
            return 32'(prod >> xlen) & mask;
         end
         3'd4: begin
            if (ub == 0)                        r = -1;
            else if (sa == minNeg && sb == -1)  r = sa;
            else                                r = sa / sb;
         end
         3'd5: r = (ub == 0) ? -1 : (ua / ub);
         3'd6: begin
            if (ub == 0)                        r = sa;
            else if (sa == minNeg && sb == -1)  r = 0;
            else                                r = sa % sb;
         end
         default: r = (ub == 0) ? ua : (ua % ub);
      endcase
      return 32'(r) & mask;
   endfunction

   function automatic bit isSpecial(input int xlen, input logic [2:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
      logic [31:0] mask;
      mask = maskOf(xlen);
      if (!op[2]) return 1'b0;
      if ((b & mask) == 0) return 1'b1;
      return ((op == 3'd4) || (op == 3'd6)) && ((a & mask) == ((mask >> 1) + 1)) &&
             ((b & mask) == mask);
   endfunction

   task automatic scrambleInputs(input bit narrow);
      if (narrow) begin
         start8 = 1'($urandom_range(0, 1)); select8 = 3'($urandom);
         data1_8 = 8'($urandom); data2_8 = 8'($urandom);
      end else begin
         start32 = 1'($urandom_range(0, 1)); select32 = 3'($urandom);
         data1_32 = $urandom; data2_32 = $urandom;
      end
   endtask

   // One full operation: accept, wait for VALID, check latency/result/zero and
   // that no second VALID follows.
   task automatic applyStimulus(input bit narrow, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expRes, input bit scramble,
                                input string tag);
      int xlen, lat, expLat, extra;
      xlen   = narrow ? 8 : 32;
      expLat = isSpecial(xlen, op, a, b) ? 1 : xlen + 1;
      @(negedge clk);
      checkOutput({tag, ".ready"}, 32'(narrow ? ready8 : ready32), 32'd1);
      if (narrow) begin
         start8 = 1'b1; select8 = op; data1_8 = a[7:0]; data2_8 = b[7:0];
      end else begin
         start32 = 1'b1; select32 = op; data1_32 = a; data2_32 = b;
      end
      @(posedge clk);
      #1;
      lat = 1;
      if (narrow) start8 = 1'b0; else start32 = 1'b0;
      while (!(narrow ? valid8 : valid32) && lat < 200) begin
         if (scramble) scrambleInputs(narrow);
         @(posedge clk);
         #1;
         lat++;
      end
      start8 = 1'b0;
      start32 = 1'b0;
      checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, ".result"}, narrow ? {24'd0, result8} : result32, expRes);
      checkOutput({tag, ".zero"}, 32'(narrow ? zero8 : zero32), 32'(expRes == 0));
      extra = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (narrow ? valid8 : valid32) extra++;
      end
      checkOutput({tag, ".singleValid"}, 32'(extra), 32'd0);
      if (!narrow) lastResult32 = expRes;
   endtask

   task automatic randomOp(input bit narrow, input string tag);
      logic [2:0]  op;
      logic [31:0] a, b, mask;
      int          kind, xlen;
      xlen = narrow ? 8 : 32;
      mask = maskOf(xlen);
      op   = 3'($urandom);
      kind = $urandom_range(0, 9);
      a    = $urandom & mask;
      b    = $urandom & mask;
      if (kind == 0) b = 0;
      if (kind == 1) begin a = (mask >> 1) + 1; b = mask; end
      applyStimulus(narrow, op, a, b, refModel(xlen, op, a, b),
                    1'($urandom_range(0, 1)), tag);
   endtask

   initial begin
      int sawValid;
      reset = 1'b1;
      start32 = 0; flush32 = 0; data1_32 = 0; data2_32 = 0; select32 = 0;
      start8 = 0; flush8 = 0; data1_8 = 0; data2_8 = 0; select8 = 0;
      lastResult32 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset.ready32", 32'(ready32), 32'd1);
      checkOutput("reset.valid32", 32'(valid32), 32'd0);
      checkOutput("reset.result32", result32, 32'd0);
      checkOutput("reset.zero32", 32'(zero32), 32'd1);
      checkOutput("reset.ready8", 32'(ready8), 32'd1);
      checkOutput("reset.result8", {24'd0, result8}, 32'd0);

      applyStimulus(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul");
      applyStimulus(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh");
      applyStimulus(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu");
      applyStimulus(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
      applyStimulus(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "div");
      applyStimulus(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "rem");
      applyStimulus(0, 3'd5, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 0, "divu");
      applyStimulus(0, 3'd7, 32'd10, 32'd3, 32'd1, 0, "remu");
      applyStimulus(0, 3'd4, 32'd6, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 0, "divNeg");
      applyStimulus(0, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "divByZero");
      applyStimulus(0, 3'd6, 32'd5, 32'd0, 32'd5, 0, "remByZero");
      applyStimulus(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "divOvf");
      applyStimulus(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "remOvf");
      applyStimulus(0, 3'd5, 32'd77, 32'd5, 32'd15, 0, "divuPrev");

      // A DIV abandoned 10 edges in must leave the previous result in place.
      @(negedge clk);
      start32 = 1'b1; select32 = 3'd4; data1_32 = 32'd100; data2_32 = 32'd7;
      @(posedge clk);
      #1 start32 = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush32 = 1'b1;
      @(posedge clk);
      #1 flush32 = 1'b0;
      checkOutput("flush.ready", 32'(ready32), 32'd1);
      checkOutput("flush.valid", 32'(valid32), 32'd0);
      checkOutput("flush.result", result32, lastResult32);
      sawValid = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (valid32) sawValid++;
      end
      checkOutput("flush.noValid", 32'(sawValid), 32'd0);
      applyStimulus(0, 3'd0, 32'd3, 32'd4, 32'd12, 0, "mulAfterFlush");

      // Reset in the middle of an operation clears RESULT.
      @(negedge clk);
      start32 = 1'b1; select32 = 3'd0; data1_32 = 32'd9; data2_32 = 32'd9;
      @(posedge clk);
      #1 start32 = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      checkOutput("midReset.ready", 32'(ready32), 32'd1);
      checkOutput("midReset.valid", 32'(valid32), 32'd0);
      checkOutput("midReset.result", result32, 32'd0);
      checkOutput("midReset.zero", 32'(zero32), 32'd1);
      lastResult32 = 32'd0;
      applyStimulus(0, 3'd0, 32'd3, 32'd4, 32'd12, 0, "mulAfterReset");

      applyStimulus(0, 3'd4, 32'd1000, 32'd7, 32'd142, 1, "scrambledDiv");
      applyStimulus(0, 3'd1, 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFFF, 1, "scrambledMulh");

      applyStimulus(1, 3'd0, 32'd7, 32'hFD, 32'hEB, 0, "x8.mul");
      applyStimulus(1, 3'd4, 32'h80, 32'hFF, 32'h80, 0, "x8.divOvf");
      applyStimulus(1, 3'd4, 32'hF9, 32'h02, 32'hFD, 0, "x8.div");
      applyStimulus(1, 3'd3, 32'hFF, 32'hFF, 32'hFE, 1, "x8.mulhu");

      for (int i = 0; i < 40; i++) randomOp(0, $sformatf("rand32[%0d]", i));
      for (int i = 0; i < 20; i++) randomOp(1, $sformatf("rand8[%0d]", i));

      checkOutput("readyValidExclusive", 32'(overlapErrors), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
